mem_responder: RTL and testbench

// - Memory-side responder for the cpu0 bus: a word RAM answering address_bus/data_bus/wr.
// - Drives data_bus on CPU reads, captures data_bus on CPU writes.
// - Includes a host loader port (valid/ready) that fills program memory while the CPU is held in reset.
// - Sits at top level beside cpu0. Its cpu_hold output is ORed into cpu0.reset.

---
 rtl/cpu0_bus_pkg.sv | 14 +
 rtl/mem_array.sv | 27 ++
 rtl/mem_responder.sv | 127 ++++++++++++
 tb/tb_mem_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu0_bus_pkg.sv
// Shared definitions for the cpu0 bus: widths, responder states and the released-bus value.
package cpu0_bus_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned BUS_W  = 16;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } resp_state_t;

   localparam logic [BUS_W-1:0] BUS_Z = 16'hzzzz;

endpackage

// File: rtl/mem_array.sv
// Word storage with one synchronous write port and an asynchronous read port.
// Contents are deliberately not reset so a responder reset keeps loaded program words.
module mem_array #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the cpu0 bus: host loader fills RAM while the CPU is held,
// then the CPU reads (zero latency) and writes the same RAM over the shared data bus.
module mem_responder
   import cpu0_bus_pkg::BUS_W;
   import cpu0_bus_pkg::BUS_Z;
   import cpu0_bus_pkg::resp_state_t;
   import cpu0_bus_pkg::LOAD;
   import cpu0_bus_pkg::RUN;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BUS_W-1:0]  address_bus,
   inout  wire  [DATA_W-1:0] data_bus,
   input  logic              wr,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_done,
   output logic              cpu_hold,
   output logic              addr_err,
   output logic [CNT_W-1:0]  ld_count,
   output logic [CNT_W-1:0]  wr_count
);

   resp_state_t       state_q, state_d;
   logic              addr_err_q, addr_err_d;
   logic [CNT_W-1:0]  ld_count_q, ld_count_d;
   logic [CNT_W-1:0]  wr_count_q, wr_count_d;

   logic              in_range;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] rd_word;
   logic              ld_beat;
   logic              cpu_wr;

   // Any set bit above the implemented word-address range is an out-of-range access.
   assign in_range = (address_bus >> ADDR_W) == '0;

   assign ld_beat = (state_q == LOAD) && ld_valid;
   assign cpu_wr  = (state_q == RUN) && wr && in_range;

   always_comb begin
      state_d    = state_q;
      addr_err_d = addr_err_q;
      ld_count_d = ld_count_q;
      wr_count_d = wr_count_q;
      unique case (state_q)
         LOAD: begin
            if (ld_done) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!in_range) begin
               addr_err_d = 1'b1;
            end
         end
         default: state_d = LOAD;
      endcase
      if (ld_beat && (ld_count_q != '1)) begin
         ld_count_d = ld_count_q + CNT_W'(1);
      end
      if (cpu_wr && (wr_count_q != '1)) begin
         wr_count_d = wr_count_q + CNT_W'(1);
      end
   end

   // Single write port: the loader owns it in LOAD, the CPU in RUN.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = ld_addr;
      mem_wdata = ld_data;
      unique case (state_q)
         LOAD: mem_we = ld_valid;
         RUN: begin
            mem_we    = cpu_wr;
            mem_waddr = address_bus[ADDR_W-1:0];
            mem_wdata = data_bus;
         end
         default: mem_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= LOAD;
         addr_err_q <= 1'b0;
         ld_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_err_q <= addr_err_d;
         ld_count_q <= ld_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (address_bus[ADDR_W-1:0]),
      .rdata (mem_rdata)
   );

   assign rd_word  = in_range ? mem_rdata : '0;
   assign data_bus = ((state_q == RUN) && !wr) ? rd_word : BUS_Z;

   assign cpu_hold = (state_q == LOAD);
   assign ld_ready = (state_q == LOAD);
   assign addr_err = addr_err_q;
   assign ld_count = ld_count_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized checks of mem_responder against a word-array reference model.
module tb_mem_responder;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 4;
   localparam int          CMAX   = 15;

   logic              clk = 1'b0;
   logic              reset;
   logic [15:0]       address_bus;
   wire  [DATA_W-1:0] data_bus;
   logic              wr;
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_done;
   logic              cpu_hold;
   logic              addr_err;
   logic [CNT_W-1:0]  ld_count;
   logic [CNT_W-1:0]  wr_count;

   logic              tb_en;
   logic [DATA_W-1:0] tb_drive;

   assign data_bus = tb_en ? tb_drive : 16'hzzzz;

   int passed = 0;
   int total  = 0;

   // Reference model: plain word array, knowledge bits, clamped counters.
   logic [15:0] ref_mem [256];
   bit          known   [256];
   int          m_ld;
   int          m_wr;
   bit          m_err;

   always #5 clk = ~clk;

   mem_responder #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .address_bus (address_bus),
      .data_bus    (data_bus),
      .wr          (wr),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_done     (ld_done),
      .cpu_hold    (cpu_hold),
      .addr_err    (addr_err),
      .ld_count    (ld_count),
      .wr_count    (wr_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : CMAX;
   endfunction

   task automatic load_beat(input logic [7:0] a, input logic [15:0] d);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      step();
      ld_valid = 1'b0;
      ref_mem[a] = d;
      known[a]   = 1'b1;
      m_ld       = sat(m_ld);
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
      wr          = 1'b1;
      tb_en       = 1'b1;
      tb_drive    = d;
      address_bus = a;
      step();
      wr    = 1'b0;
      tb_en = 1'b0;
      if (a < 16'd256) begin
         ref_mem[a[7:0]] = d;
         known[a[7:0]]   = 1'b1;
         m_wr            = sat(m_wr);
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic cpu_read(input string tag, input logic [15:0] a);
      wr          = 1'b0;
      address_bus = a;
      #1;
      if (a >= 16'd256) begin
         chk(tag, 32'(data_bus), 32'h0);
      end else if (known[a[7:0]]) begin
         chk(tag, 32'(data_bus), 32'(ref_mem[a[7:0]]));
      end
      step();
      if (a >= 16'd256) m_err = 1'b1;
   endtask

   task automatic model_reset();
      m_ld  = 0;
      m_wr  = 0;
      m_err = 1'b0;
   endtask

   initial begin
      reset = 1'b1; address_bus = '0; wr = 1'b0; ld_valid = 1'b0; ld_addr = '0;
      ld_data = '0; ld_done = 1'b0; tb_en = 1'b0; tb_drive = '0;
      for (int i = 0; i < 256; i++) begin
         known[i] = 1'b0; ref_mem[i] = '0;
      end
      model_reset();
      #12;
      chk("rst_hold", 32'(cpu_hold), 32'h1);
      chk("rst_ready", 32'(ld_ready), 32'h1);
      chk("rst_err", 32'(addr_err), 32'h0);
      chk("rst_ldcnt", 32'(ld_count), 32'h0);
      chk("rst_wrcnt", 32'(wr_count), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      step();

      // Load three beats, then end loading.
      load_beat(8'h00, 16'h1234);
      load_beat(8'h01, 16'hABCD);
      load_beat(8'h02, 16'h0F0F);
      ld_done = 1'b1;
      #1;
      chk("hold_before_edge", 32'(cpu_hold), 32'h1);
      step();
      ld_done = 1'b0;
      chk("hold_after_done", 32'(cpu_hold), 32'h0);
      chk("ready_run", 32'(ld_ready), 32'h0);
      chk("ldcnt_3", 32'(ld_count), 32'd3);

      // Zero-latency read, then write and read-back.
      cpu_read("rd_0001", 16'h0001);
      cpu_write(16'h0002, 16'h5555);
      cpu_read("rd_0002_new", 16'h0002);
      chk("wrcnt_1", 32'(wr_count), 32'd1);

      // Out-of-range read and write.
      cpu_read("rd_oor", 16'h0100);
      chk("err_set", 32'(addr_err), 32'h1);
      cpu_write(16'h0100, 16'h9999);
      chk("wrcnt_oor", 32'(wr_count), 32'd1);
      cpu_read("rd_0000_kept", 16'h0000);
      chk("err_sticky", 32'(addr_err), 32'h1);

      // Asynchronous reset mid-cycle while the responder drives a read of 0x1234.
      address_bus = 16'h0000;
      wr          = 1'b0;
      #2;
      reset    = 1'b1;
      tb_en    = 1'b1;
      tb_drive = 16'h0000;
      #1;
      chk("async_hold", 32'(cpu_hold), 32'h1);
      chk("async_bus_released", 32'(data_bus), 32'h0);
      chk("async_ldcnt", 32'(ld_count), 32'h0);
      chk("async_wrcnt", 32'(wr_count), 32'h0);
      chk("async_err", 32'(addr_err), 32'h0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      tb_en = 1'b0;
      ld_done = 1'b1;
      step();
      ld_done = 1'b0;
      cpu_read("rd_preserved", 16'h0000);

      // Beat accepted in the same cycle as ld_done.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step();
      ld_valid = 1'b1; ld_addr = 8'h05; ld_data = 16'h7777; ld_done = 1'b1;
      step();
      ld_valid = 1'b0; ld_done = 1'b0;
      ref_mem[5] = 16'h7777; known[5] = 1'b1; m_ld = sat(m_ld);
      chk("done_beat_run", 32'(cpu_hold), 32'h0);
      chk("done_beat_cnt", 32'(ld_count), 32'd1);
      cpu_read("rd_0005", 16'h0005);

      // Loader ignored in RUN.
      ld_valid = 1'b1; ld_addr = 8'h00; ld_data = 16'hFFFF;
      #1;
      chk("run_ready", 32'(ld_ready), 32'h0);
      step();
      ld_valid = 1'b0;
      chk("run_ldcnt", 32'(ld_count), 32'd1);
      cpu_read("run_rd_0000", 16'h0000);

      // Randomized phase: overwriting loads past counter saturation, then mixed CPU traffic.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step();
      for (int i = 0; i < 24; i++) begin
         load_beat(8'($urandom_range(0, 15)), 16'($urandom));
      end
      chk("rnd_ldcnt_sat", 32'(ld_count), 32'(m_ld));
      ld_done = 1'b1;
      step();
      ld_done = 1'b0;
      for (int i = 0; i < 80; i++) begin
         logic [15:0] a;
         if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(256, 65535));
         else a = 16'($urandom_range(0, 15));
         if (i == 40) chk("rnd_err_mid", 32'(addr_err), 32'(m_err));
         if ($urandom_range(0, 1) == 1) cpu_write(a, 16'($urandom));
         else cpu_read("rnd_rd", a);
      end
      chk("rnd_wrcnt", 32'(wr_count), 32'(m_wr));
      chk("rnd_ldcnt_hold", 32'(ld_count), 32'(m_ld));
      chk("rnd_err", 32'(addr_err), 32'(m_err));
      for (int a = 0; a < 16; a++) begin
         cpu_read("rnd_sweep", 16'(a));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
